// File: rtl/mult_arb_pkg.sv
// Shared types and sizing helpers for the multiplier sequencer/arbiter.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int N_REQ_DEF   = 2;
  localparam int WIDTH_DEF   = 16;
  localparam int TIMEOUT_DEF = 64;

  // Timeout counter must be able to hold the value TIMEOUT itself.
  function automatic int tmr_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // Grant index width; never zero so single-bit vectors stay legal.
  function automatic int idx_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first set request at or after ptr,
// searching upward with wrap. Kept generic so other shared units can reuse it.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Sequencer and round-robin arbiter sharing one sequential multiplier among
// N_REQ requesters, with a per-operation cycle budget.
//
// state | meaning
// ------+-----------------------------------------------------------
// ARB   | wait for Idle=1 and a request; latch winner and operands
// START | hold St high until the multiplier drops Idle
// BUSY  | wait for Done (or budget expiry)
// RESP  | one-cycle Valido/Erro pulse, advance round-robin pointer
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [N_REQ-1:0]       Req,
  input  logic [N_REQ*WIDTH-1:0] OpA,
  input  logic [N_REQ*WIDTH-1:0] OpB,
  output logic [N_REQ-1:0]       Ack,
  output logic [N_REQ-1:0]       Valido,
  output logic [N_REQ-1:0]       Erro,
  output logic [2*WIDTH-1:0]     Resultado,
  output logic                   St,
  output logic [WIDTH-1:0]       Multiplicando,
  output logic [WIDTH-1:0]       Multiplicador,
  input  logic                   Idle,
  input  logic                   Done,
  input  logic [2*WIDTH-1:0]     Produto
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int CNT_W = tmr_width(TIMEOUT);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] g;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             expire;

  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gidx;
  logic             gany;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req (Req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  // Budget counts every START/BUSY cycle; expiry is the edge where it would reach TIMEOUT.
  assign cnt_nxt = cnt + CNT_W'(1);
  assign expire  = (cnt_nxt == CNT_W'(TIMEOUT));

  // Sequencer FSM with registered handshake, operand and result outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state         <= ARB;
      ptr           <= '0;
      g             <= '0;
      cnt           <= '0;
      St            <= 1'b0;
      Ack           <= '0;
      Valido        <= '0;
      Erro          <= '0;
      Resultado     <= '0;
      Multiplicando <= '0;
      Multiplicador <= '0;
    end else begin
      Ack    <= '0;
      Valido <= '0;
      Erro   <= '0;
      case (state)
        ARB: begin
          // Idle gate also covers a multiplier still running after timeout or reset.
          if (Idle && gany) begin
            g             <= gidx;
            Multiplicando <= OpA[int'(gidx)*WIDTH +: WIDTH];
            Multiplicador <= OpB[int'(gidx)*WIDTH +: WIDTH];
            Ack           <= gnt;
            St            <= 1'b1;
            cnt           <= '0;
            state         <= START;
          end
        end
        START: begin
          cnt <= cnt_nxt;
          if (expire) begin
            St        <= 1'b0;
            Resultado <= '0;
            Erro[g]   <= 1'b1;
            state     <= RESP;
          end else if (!Idle) begin
            St    <= 1'b0;
            state <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt_nxt;
          // Done takes priority over a simultaneous expiry.
          if (Done) begin
            Resultado <= Produto;
            Valido[g] <= 1'b1;
            state     <= RESP;
          end else if (expire) begin
            Resultado <= '0;
            Erro[g]   <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          ptr   <= (int'(g) == N_REQ - 1) ? '0 : g + IDX_W'(1);
          state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
